// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg : shared encodings and types for the load/store unit         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } lsu_state_e;

  // Unsigned variants only exist for loads, so a store with funct3[2] set is rejected.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic st);
    logic legal;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
            (f3 == F3_BU) || (f3 == F3_HU);
    return !legal || (f3[2] && st);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// +----------------------------------------------------------------------+
// | lsu_align : byte enables, store lane replication, load extension     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = mem_rdata[{addr_lo, 3'b000} +: 8];
  assign w_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    be        = BE_WORD;
    wdata_rep = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        be        = BE_BYTE << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        // Halfword lanes only ever start on an even byte.
        be        = BE_HALF << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = mem_rdata;
    unique case (funct3)
      F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_data = {24'd0, w_byte};
      F3_H:    load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   load_data = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit : single-outstanding RISC-V style load/store unit    |
// | Option macro LSU_MISALIGN_TRAP_EN adds misalign trapping. Rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  lsu_state_e    state_q, state_d;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_capture;
  logic          w_fin_err;
  logic          w_load_fire;
  logic [31:0]   w_load_data;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_fin_mis;
  logic r_mis;
`endif

  always_comb begin
    state_d     = state_q;
    w_capture   = 1'b0;
    w_fin_err   = 1'b0;
    w_load_fire = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    w_fin_mis   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          w_capture = 1'b1;
          if (f3_illegal(funct3, we)) begin
            state_d   = ST_DONE;
            w_fin_err = 1'b1;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (f3_misaligned(funct3, addr[1:0])) begin
            state_d   = ST_DONE;
            w_fin_mis = 1'b1;
          end
`endif
          else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        mem_re = !r_we;
        mem_we = r_we;
        // A late ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          state_d     = ST_DONE;
          w_load_fire = !r_we;
        end else if (r_cnt == CNT_LAST) begin
          state_d   = ST_DONE;
          w_fin_err = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_cnt    <= '0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_fin_err;
      if (w_capture) begin
        r_we     <= we;
        r_funct3 <= funct3;
        r_addr   <= addr;
        r_wdata  <= wdata;
        r_cnt    <= '0;
      end else if (state_q == ST_ISSUE) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load_fire) r_rdata <= w_load_data;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_mis <= 1'b0;
    else         r_mis <= w_fin_mis;
  end
  assign misalign = r_mis;
`endif

  lsu_align u_align (
    .funct3    (r_funct3),
    .addr_lo   (r_addr[1:0]),
    .wdata     (r_wdata),
    .mem_rdata (mem_rdata),
    .be        (mem_be),
    .wdata_rep (mem_wdata),
    .load_data (w_load_data)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign mem_addr = r_addr[31:2];

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum ISSUE cycles to wait for mem_ack before an error completion.
REQ-002 The block SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req  input  1  access request, sampled in IDLE only.
REQ-005 The block SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 The block SHALL have port funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 The block SHALL have port addr  input  32  byte address, taken from the ALU result s.
REQ-008 The block SHALL have port wdata  input  32  store data (rs2).
REQ-009 The block SHALL have ports busy, done, err  output  1 each  status; done is a one-cycle completion pulse.
REQ-010 The block SHALL have port rdata  output  32  extended load result, valid while done=1.
REQ-011 The block SHALL have port misalign  output  1  misaligned-access flag; present only under LSU_MISALIGN_TRAP_EN.
REQ-012 The block SHALL have ports mem_addr  output  30 (word address), mem_be  output  4, mem_wdata  output  32, mem_re/mem_we  output  1 each.
REQ-013 The block SHALL have ports mem_rdata  input  32 and mem_ack  input  1  memory response.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE and DONE.
REQ-015 In IDLE with req=1, the block SHALL capture we, funct3, addr and wdata and enter ISSUE on the next edge; busy=0 only in IDLE.
REQ-016 In ISSUE, mem_re (load) or mem_we (store) SHALL be held at 1, with stable mem_addr=addr[31:2], mem_be and mem_wdata, until mem_ack=1.
REQ-017 On mem_ack in ISSUE, the block SHALL enter DONE; a load SHALL register rdata from mem_rdata in that same edge.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-019 The minimum latency SHALL be: req at cycle N, ISSUE at N+1, ack at N+1, done at N+2.
REQ-020 The byte-enable pattern SHALL be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111.
REQ-021 Store data SHALL be lane-replicated: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-022 Load data SHALL select the addressed lane; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-023 An ISSUE cycle counter SHALL run; reaching ACK_TIMEOUT without ack SHALL drop the strobes, enter DONE, and assert err with done.
REQ-024 Illegal funct3 (011, 110, 111), or 1xx combined with we=1, SHALL skip ISSUE, go straight to DONE with err=1, and perform no memory strobe.
REQ-025 req while busy=1 SHALL be ignored; mem_ack outside ISSUE SHALL be ignored.
REQ-026 When done=0, rdata SHALL hold its last value; err and misalign SHALL be 0.

Reset
REQ-027 resetn=0 SHALL asynchronously force IDLE, with busy, done, err, misalign, mem_re and mem_we at 0, rdata at 0, and the counter at 0.
REQ-028 Reset during ISSUE SHALL abandon the access with no completion pulse.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined, H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL skip ISSUE, enter DONE, and assert misalign=1 (err=0) with done.
REQ-030 Without LSU_MISALIGN_TRAP_EN, the misalign port SHALL be absent, and the access SHALL proceed with addr[0] ignored for H/HU and addr[1:0] ignored for W.

Structure
REQ-031 Package lsu_pkg SHALL hold the funct3 encodings, the state enum and the byte-enable constants.
REQ-032 Sub-module lsu_align SHALL be the combinational lane logic (be, store replication, load extend), instantiated once.

Verification
REQ-033 The bench SHALL check: LB, addr=0x103, mem_rdata=0x80FF_FFFF, ack same cycle -> mem_be=1000, rdata=0xFFFF_FF80, done at N+2.
REQ-034 The bench SHALL check: SH, addr=0x22, wdata=0x1234_ABCD -> mem_addr=0x8, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we held until ack.
REQ-035 The bench SHALL check: LW with no ack for 15 cycles -> strobes drop, done=1 with err=1, rdata unchanged.
REQ-036 The bench SHALL check: LW addr=0x2 -> with the macro, misalign=1 and no mem_re; without it, mem_be=1111 and mem_addr=0x0.
REQ-037 The bench SHALL check: funct3=011 -> done next cycle with err=1 and no strobe; a second req while busy produces no second access.
REQ-038 The bench SHALL check: resetn low mid-ISSUE -> mem_re=0 immediately, no done, and the next req completes normally.
